// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clkdiv block: FSM state encoding, the smallest
// legal divisor and a helper that classifies a requested divisor.
package clkdiv_pkg;

  // Controller states. IDLE is the only state in which the counter is parked.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Smallest divisor that still produces a toggling output.
  localparam int DIV_MIN = 2;

  // True when a requested divisor can be applied (0 and 1 are rejected).
  function automatic logic div_is_legal(input logic [31:0] div);
    return div >= 32'(DIV_MIN);
  endfunction

endpackage : clkdiv_pkg

// File: rtl/clkdiv_cnt.sv
// Wrapping phase counter for clkdiv: counts 0..limit while run is high,
// can be forced to a value with load, and flags the terminal count.
module clkdiv_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Terminal count is only meaningful while counting.
  assign wrap = run && (cnt_reg == limit);
  assign cnt  = cnt_reg;

  // Next count: load wins, otherwise increment and wrap at the limit.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (run) begin
      if (cnt_reg == limit) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule : clkdiv_cnt

// File: rtl/clkdiv.sv
// Programmable integer clock divider with a divisor handshake.
// Divisor changes requested while running are staged and applied only at the
// counter wrap so no output phase is ever shortened.
// Optional feature: define CLKDIV_ODD_DUTY_EN to stretch the high phase of odd
// divisors by half a clk period (negedge flop), giving 50% duty for odd N.
module clkdiv
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             clk_en,
  output logic             busy,
  output logic             err
);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             err_reg, err_next;
  logic             clk_out_reg, clk_out_next;

  logic [DIV_W-1:0] cnt;
  logic             wrap;
  logic             run;
  logic             park;
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] half;
  logic             handshake;
  logic             legal;
  logic             accept;

  // Counter runs in every state except IDLE, where it is held at zero.
  assign run   = (state_reg != ST_IDLE);
  assign park  = (state_reg == ST_IDLE);
  assign limit = div_reg - DIV_W'(1);
  assign half  = div_reg >> 1;

  assign handshake = div_valid && div_ready;
  assign legal     = div_is_legal(32'(div_in));
  assign accept    = handshake && legal;

  clkdiv_cnt #(
    .W(DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (park),
    .load_val ('0),
    .limit    (limit),
    .cnt      (cnt),
    .wrap     (wrap)
  );

  // Next-state, divisor staging and error detection.
  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    err_next        = handshake && !legal;

    // A staged divisor takes effect exactly at the period boundary.
    if (wrap && pend_valid_reg) begin
      div_next        = pend_reg;
      pend_valid_next = 1'b0;
    end

    unique case (state_reg)
      ST_IDLE: begin
        // Nothing is running, so a new divisor can be used immediately.
        if (accept) begin
          div_next = div_in;
        end
        if (en) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          pend_next       = div_in;
          pend_valid_next = 1'b1;
        end
        if (!en) begin
          state_next = ST_DRAIN;
        end else if (accept) begin
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en) begin
          state_next = ST_DRAIN;
        end else if (wrap) begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Finish the current period even if en comes back.
        if (wrap) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Registered output phase; low whenever the counter is parked.
    clk_out_next = run && (cnt < half);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      div_reg        <= DIV_W'(DIV_RST);
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      clk_out_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      err_reg        <= err_next;
      clk_out_reg    <= clk_out_next;
    end
  end

  // Enable pulse on the last count of a period that is followed by another.
  assign clk_en    = wrap && (state_next != ST_IDLE);
  assign div_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
  assign busy      = (state_reg != ST_IDLE);
  assign err       = err_reg;

`ifdef CLKDIV_ODD_DUTY_EN
  logic clk_out_neg_reg;

  // Half-cycle delayed copy of the output, used to stretch odd-N high phases.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out_neg_reg <= 1'b0;
    end else begin
      clk_out_neg_reg <= clk_out_reg;
    end
  end

  assign clk_out = clk_out_reg | (div_reg[0] & clk_out_neg_reg);
`else
  assign clk_out = clk_out_reg;
`endif

endmodule : clkdiv

// File: tb/tb_clkdiv.sv
// Directed testbench for clkdiv: linear stimulus with hand-computed
// expectations, checked by immediate assertions.
module tb_clkdiv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       clk_out;
  logic       clk_en;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] v_co, v_ce, v_bz, v_er;

  clkdiv #(
    .DIV_W   (8),
    .DIV_RST (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .clk_en    (clk_en),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record outputs after each of n clock edges; bit i holds edge i.
  task automatic sample(input int n);
    v_co = '0;
    v_ce = '0;
    v_bz = '0;
    v_er = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      v_co[i] = clk_out;
      v_ce[i] = clk_en;
      v_bz[i] = busy;
      v_er[i] = err;
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    en        = 1'b0;
    div_valid = 1'b0;
    div_in    = 8'd0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_clk_out", clk_out, 16'd0);
    check("rst_clk_en", clk_en, 16'd0);
    check("rst_err", err, 16'd0);
    check("rst_busy", busy, 16'd0);
    check("rst_div_ready", div_ready, 16'd1);
    tick();
    tick();

    // N=2 (reset divisor): toggle every cycle, enable every 2nd cycle
    rst_n = 1'b1;
    en    = 1'b1;
    sample(8);
    check("n2_clk_out", v_co, 16'h00AA);
    check("n2_clk_en", v_ce, 16'h00AA);
    check("n2_busy", v_bz, 16'h00FF);
    $display("n2 run: clk_out=%h clk_en=%h busy=%h", v_co, v_ce, v_bz);

    // asynchronous reset while clk_out is high
    rst_n = 1'b0;
    #1;
    check("midrst_clk_out", clk_out, 16'd0);
    check("midrst_busy", busy, 16'd0);
    check("midrst_div_ready", div_ready, 16'd1);
    tick();

    // load N=4 directly in IDLE, then start
    rst_n     = 1'b1;
    en        = 1'b0;
    div_valid = 1'b1;
    div_in    = 8'd4;
    #1;
    check("idle_div_ready", div_ready, 16'd1);
    tick();
    div_valid = 1'b0;
    en        = 1'b1;
    tick();
    check("n4_start_busy", busy, 16'd1);
    check("n4_start_clk_out", clk_out, 16'd0);
    $display("load N=4 in IDLE, running");

    // illegal divisor 1: err pulse, period stays 4
    div_valid = 1'b1;
    div_in    = 8'd1;
    tick();
    check("ill_err", err, 16'd1);
    check("ill_div_ready", div_ready, 16'd1);
    check("ill_clk_out", clk_out, 16'd1);
    div_valid = 1'b0;
    sample(4);
    check("ill_period_clk_out", v_co, 16'h0009);
    check("ill_err_pulse", v_er, 16'h0000);
    $display("illegal N=1: clk_out=%h err=%h", v_co, v_er);

    // request N=6 at cnt=1: current 2/2 period finishes, then 3/3
    div_valid = 1'b1;
    div_in    = 8'd6;
    #1;
    check("req6_ready_before", div_ready, 16'd1);
    tick();
    check("req6_ready_pend", div_ready, 16'd0);
    check("req6_clk_out", clk_out, 16'd1);
    div_valid = 1'b0;
    sample(9);
    check("n4to6_clk_out", v_co, 16'h011C);
    check("n4to6_clk_en", v_ce, 16'h0041);
    $display("N 4->6: clk_out=%h clk_en=%h", v_co, v_ce);

    // request N=5 at cnt=1, wait for the switch at wrap
    div_valid = 1'b1;
    div_in    = 8'd5;
    tick();
    div_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("n5_start_clk_out", clk_out, 16'd0);
    sample(10);
`ifdef CLKDIV_ODD_DUTY_EN
    check("n5_clk_out", v_co, 16'h00E7);
`else
    check("n5_clk_out", v_co, 16'h0063);
`endif
    $display("N=5: clk_out=%h", v_co);

    // switch to N=8, then drop en at cnt=1
    tick();
    div_valid = 1'b1;
    div_in    = 8'd8;
    tick();
    div_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("n8_cnt1_clk_out", clk_out, 16'd1);
    en = 1'b0;
    sample(7);
    check("drain_clk_out", v_co, 16'h0007);
    check("drain_busy", v_bz, 16'h003F);
    check("drain_clk_en", v_ce, 16'h0000);
    tick();
    check("idle_clk_out", clk_out, 16'd0);
    check("idle_busy", busy, 16'd0);
    $display("drain N=8: clk_out=%h busy=%h clk_en=%h", v_co, v_bz, v_ce);

    // reset at cnt=2 with N=10 pending
    en = 1'b1;
    tick();
    tick();
    div_valid = 1'b1;
    div_in    = 8'd10;
    tick();
    div_valid = 1'b0;
    check("pend10_ready", div_ready, 16'd0);
    check("pend10_clk_out", clk_out, 16'd1);
    rst_n = 1'b0;
    #1;
    check("prst_clk_out", clk_out, 16'd0);
    check("prst_busy", busy, 16'd0);
    check("prst_div_ready", div_ready, 16'd1);
    check("prst_clk_en", clk_en, 16'd0);
    check("prst_err", err, 16'd0);
    tick();
    rst_n = 1'b1;
    sample(4);
    check("post_rst_clk_out", v_co, 16'h000A);
    check("post_rst_clk_en", v_ce, 16'h000A);
    $display("after reset with pending: clk_out=%h clk_en=%h", v_co, v_ce);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_clkdiv

// File: doc/clkdiv.md
CLKDIV -- requirements
Module: clkdiv

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning divisor register width.
REQ-002 SHALL have parameter DIV_RST, default 2, meaning divisor loaded at reset (legal range 2..2^DIV_W-1).
REQ-003 SHALL have port clk  in  1  single clock, the buffered system clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  in  1  run enable.
REQ-006 SHALL have port div_in  in  DIV_W  requested divisor N.
REQ-007 SHALL have port div_valid  in  1  divisor request valid.
REQ-008 SHALL have port div_ready  out  1  divisor request can be accepted.
REQ-009 SHALL have port clk_out  out  1  divided clock.
REQ-010 SHALL have port clk_en  out  1  one-cycle pulse preceding each clk_out rising edge.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have port err  out  1  one-cycle pulse on an illegal divisor request.

Function
REQ-013 SHALL keep counter cnt in 0..N-1, incrementing by one per clk in RUN, PEND and DRAIN, and wrapping N-1 -> 0.
REQ-014 SHALL drive clk_out from a register, high while cnt < floor(N/2) and low otherwise; even N gives 50% duty.
REQ-015 SHALL assert clk_en in the cycle where cnt == N-1 and the next state is not IDLE.
REQ-016 SHALL implement states IDLE, RUN, PEND and DRAIN.
- IDLE -> RUN on en=1.
- RUN -> PEND on a handshake.
- RUN or PEND -> DRAIN on en=0.
- DRAIN -> IDLE at wrap.
- PEND -> RUN at wrap, when the pending divisor is applied.
REQ-017 SHALL treat a handshake as div_valid && div_ready; div_ready is 1 in IDLE and RUN and 0 in PEND and DRAIN.
REQ-018 SHALL load an accepted div_in directly in IDLE; in RUN it SHALL stage the value and apply it only at wrap, so no clk_out phase is shortened.
REQ-019 SHALL accept an illegal div_in (0 or 1), pulse err for one cycle, leave the divisor unchanged and stay in the current state.
REQ-020 SHALL, on en=0 during PEND, apply the pending divisor at the DRAIN wrap.
REQ-021 SHALL hold cnt=0 and clk_out=0 in IDLE; the first clk_out rise SHALL occur one cycle after entering RUN.
REQ-022 SHALL, when en returns to 1 during DRAIN, let DRAIN finish its wrap first, pass through IDLE for one cycle, then go to RUN.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set state=IDLE, cnt=0, divisor=DIV_RST, pending cleared, clk_out=0, clk_en=0, err=0, busy=0 and div_ready=1.
REQ-024 SHALL, on reset mid-period, drop clk_out low immediately and discard any pending divisor.

Configuration
REQ-025 SHALL use macro CLKDIV_ODD_DUTY_EN; when defined, odd N SHALL use a negedge-clk flop that delays the falling edge by half a clk period, giving exactly 50% duty.
REQ-026 SHALL, without CLKDIV_ODD_DUTY_EN, give odd N high for floor(N/2) cycles and low for ceil(N/2), using posedge logic only.

Structure
REQ-027 SHALL place state encoding and constant DIV_MIN=2 in shared package clkdiv_pkg.
REQ-028 SHALL put the wrapping counter with load and wrap flag in sub-module clkdiv_cnt; all other logic SHALL be in clkdiv.

Verification
REQ-029 SHALL cover: reset, en=1, N=2 -> clk_out toggles every cycle; clk_en pulses every 2nd cycle; busy=1.
REQ-030 SHALL cover: N=4 running, request div_in=6 at cnt=1 -> div_ready=0; current period completes with 2 high/2 low, then 3 high/3 low.
REQ-031 SHALL cover: request div_in=1 -> err pulses one cycle; period stays 4; div_ready stays 1.
REQ-032 SHALL cover: N=5 -> without macro 2 high/3 low cycles; with CLKDIV_ODD_DUTY_EN high for 2.5 clk periods.
REQ-033 SHALL cover: en=0 at cnt=1 with N=8 -> period finishes (cnt reaches 7), then IDLE with clk_out=0 and busy=0.
REQ-034 SHALL cover: rst_n low at cnt=2 with pending 10 -> outputs are at reset values immediately; after release the divisor is DIV_RST.
